// File: rtl/midi_pkg.sv
// midi_pkg: shared types and constants for the MIDI message decoder.
//   evt_type_e  - event code carried on evt_type
//   state_e     - decoder FSM states
//   midi_evt_t  - one FIFO entry {typ, chan, d1, d2}, 21 bits
//   is_rt_evt() - true for the realtime bytes that may become events
//                 (used only when MIDI_RT_EVT_EN is defined)
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    BEND     = 3'd6,
    RT       = 3'd7
  } evt_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_e;

  localparam logic [7:0] ST_SYSEX  = 8'hF0;
  localparam logic [7:0] ST_EOX    = 8'hF7;
  localparam logic [7:0] ST_RT_MIN = 8'hF8;

  typedef struct packed {
    evt_type_e  typ;
    logic [3:0] chan;
    logic [6:0] d1;
    logic [6:0] d2;
  } midi_evt_t;

  // Clock, start, continue and stop are the only realtime bytes worth
  // forwarding to the synth controller.
  function automatic logic is_rt_evt(input logic [7:0] b);
    return (b == 8'hF8) || (b == 8'hFA) || (b == 8'hFB) || (b == 8'hFC);
  endfunction

endpackage

// File: rtl/midi_evt_fifo.sv
// midi_evt_fifo: synchronous first-word-fall-through FIFO of midi_evt_t.
// The head entry and the empty/full flags come straight from registers.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_push, i_data      write request and entry (dropped when full w/o pop)
//   i_pop               consume the head entry (ignored when empty)
//   o_data              head entry, valid when ~o_empty
//   o_full, o_empty     occupancy flags
module midi_evt_fifo
  import midi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_push,
  input  midi_evt_t i_data,
  input  logic      i_pop,
  output midi_evt_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  midi_evt_t         r_mem [DEPTH];
  midi_evt_t         r_head;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_pop;
  logic              w_wr;
  logic [AW-1:0]     w_rd_nxt;
  logic [CW-1:0]     w_left;
  logic [CW-1:0]     w_cnt_nxt;
  midi_evt_t         w_head_nxt;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_data  = r_head;

  // A write into a full FIFO is only accepted when the head leaves in the
  // same cycle; the slot being overwritten is exactly the one popped.
  assign w_pop     = i_pop & ~o_empty;
  assign w_wr      = i_push & (~o_full | w_pop);
  assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);
  assign w_left    = r_count - CW'(w_pop);
  assign w_cnt_nxt = w_left + CW'(w_wr);

  // Next head: the incoming entry if nothing older survives this cycle,
  // otherwise the stored entry the read pointer moves to.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_head_nxt = '0;
    if (w_left == '0) begin
      if (w_wr) w_head_nxt = i_data;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      r_wr_ptr <= r_wr_ptr + AW'(w_wr);
      r_count  <= w_cnt_nxt;
      r_head   <= w_head_nxt;
    end
  end

endmodule

// File: rtl/midi_msg_decoder.sv
// midi_msg_decoder: turns the MIDI UART byte stream into channel-voice
// events, tracking running status, and queues them in an event FIFO.
// Optional: define MIDI_RT_EVT_EN to forward F8/FA/FB/FC as RT events.
// Ports:
//   reg_clk, reset_reg_N      clock, synchronous active-low reset
//   byteready_u, midi_in_data_u  UART byte-available level and byte
//   evt_valid, evt_ready      event handshake toward the synth controller
//   evt_type/chan/d1/d2       head event fields
//   overflow, overflow_clr    sticky dropped-event flag and its clear
//   run_status                current running status byte (0 = none)
module midi_msg_decoder
  import midi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CHANNEL    = 0,
  parameter bit OMNI       = 1'b1
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       byteready_u,
  input  logic [7:0] midi_in_data_u,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_type,
  output logic [3:0] evt_chan,
  output logic [6:0] evt_d1,
  output logic [6:0] evt_d2,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic [7:0] run_status
);

  logic       r_byteready_q;
  logic       r_byte_stb;
  logic [7:0] r_byte;
  state_e     r_state;
  logic [7:0] r_run_status;
  logic [6:0] r_d1;
  logic       r_push;
  midi_evt_t  r_evt;
  logic       r_overflow;

  state_e     w_state_nxt;
  logic [7:0] w_run_nxt;
  logic [6:0] w_d1_nxt;
  logic [6:0] w_d2;
  logic       w_msg_done;
  logic       w_push_nxt;
  midi_evt_t  w_evt_nxt;
  midi_evt_t  w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_drop;

  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run_status;
    w_d1_nxt    = r_d1;
    w_d2        = '0;
    w_msg_done  = 1'b0;
    w_push_nxt  = 1'b0;
    w_evt_nxt   = '0;

    if (r_byte_stb) begin
      if (r_byte >= ST_RT_MIN) begin
        // Realtime bytes never disturb the message in progress.
`ifdef MIDI_RT_EVT_EN
        if (is_rt_evt(r_byte)) begin
          w_push_nxt    = 1'b1;
          w_evt_nxt.typ = RT;
          w_evt_nxt.d1  = r_byte[6:0];
        end
`endif
      end else if (r_byte == ST_SYSEX) begin
        w_run_nxt   = '0;
        w_state_nxt = SYSEX;
      end else if (r_byte > ST_SYSEX && r_byte <= ST_EOX) begin
        w_run_nxt   = '0;
        w_state_nxt = IDLE;
      end else if (r_byte[7]) begin
        w_run_nxt   = r_byte;
        w_state_nxt = WAIT_D1;
      end else begin
        case (r_state)
          WAIT_D1: begin
            w_d1_nxt = r_byte[6:0];
            // Cn / Dn carry a single data byte.
            if (r_run_status[7:5] == 3'b110) w_msg_done = 1'b1;
            else                             w_state_nxt = WAIT_D2;
          end
          WAIT_D2: begin
            w_d2        = r_byte[6:0];
            w_msg_done  = 1'b1;
            w_state_nxt = WAIT_D1;
          end
          default: ;
        endcase
      end
    end

    if (w_msg_done) begin
      // Status 8n..En maps directly onto the event code via bits [6:4].
      w_evt_nxt.typ  = evt_type_e'(r_run_status[6:4]);
      if (w_evt_nxt.typ == NOTE_ON && w_d2 == 7'd0) w_evt_nxt.typ = NOTE_OFF;
      w_evt_nxt.chan = r_run_status[3:0];
      w_evt_nxt.d1   = w_d1_nxt;
      w_evt_nxt.d2   = w_d2;
      w_push_nxt     = OMNI || (r_run_status[3:0] == 4'(CHANNEL));
    end
  end

  assign w_pop  = evt_ready & evt_valid;
  assign w_drop = r_push & w_full & ~w_pop;

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      r_byteready_q <= 1'b0;
      r_byte_stb    <= 1'b0;
      r_byte        <= '0;
      r_state       <= IDLE;
      r_run_status  <= '0;
      r_d1          <= '0;
      r_push        <= 1'b0;
      r_evt         <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_byteready_q <= byteready_u;
      r_byte_stb    <= byteready_u & ~r_byteready_q;
      r_byte        <= midi_in_data_u;
      r_state       <= w_state_nxt;
      r_run_status  <= w_run_nxt;
      r_d1          <= w_d1_nxt;
      r_push        <= w_push_nxt;
      r_evt         <= w_evt_nxt;
      if (overflow_clr) r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
    end
  end

  midi_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (reg_clk),
    .i_rst_n (reset_reg_N),
    .i_push  (r_push),
    .i_data  (r_evt),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid  = ~w_empty;
  assign evt_type   = w_head.typ;
  assign evt_chan   = w_head.chan;
  assign evt_d1     = w_head.d1;
  assign evt_d2     = w_head.d2;
  assign overflow   = r_overflow;
  assign run_status = r_run_status;

endmodule

// File: doc/midi_msg_decoder.md
Name: midi_msg_decoder

Overview:
- Sits directly downstream of the MIDI UART receiver. Consumes its byte strobe and data byte, tracks running status itself, and assembles complete channel-voice messages.
- Each completed message is pushed as one event into a small FIFO with a valid/ready output toward the synth controller (voice allocator, CC registers).
- Filters to one MIDI channel or accepts all channels (omni).

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16
- CHANNEL, 0, accepted MIDI channel 0..15 when OMNI=0
- OMNI, 1, 1 = accept all channels; 0 = keep only CHANNEL

Ports:
- reg_clk  in  1  single clock; all logic on posedge
- reset_reg_N  in  1  synchronous reset, active-low
- byteready_u  in  1  byte-available level from UART; may stay high many cycles per byte
- midi_in_data_u  in  8  received byte; stable while byteready_u high
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_type  out  3  event code (package enum)
- evt_chan  out  4  MIDI channel of event
- evt_d1  out  7  data byte 1 (note / controller / program / bend LSB)
- evt_d2  out  7  data byte 2 (velocity / value / bend MSB); 0 for 1-data messages
- overflow  out  1  sticky: an event was dropped on a full FIFO
- overflow_clr  in  1  clears overflow
- run_status  out  8  current running status byte; 0 = none

Behaviour:
- Reset (reset_reg_N low at a posedge): all outputs 0; FIFO emptied; FSM to IDLE; edge-detect register 0. Reset mid-message discards the partial message.
- Byte strobe: byte_stb = byteready_u & ~byteready_q, registered. One strobe per rising edge; a level held any number of cycles counts as one byte.
- Byte classes:
  - F8..FF (realtime): never alter the FSM or running status; dropped unless MIDI_RT_EVT_EN.
  - 80..EF: sets run_status; FSM to WAIT_D1.
  - F0: clears run_status; FSM to SYSEX.
  - F1..F7: clear run_status; FSM to IDLE.
  - 00..7F: data byte.
- FSM states IDLE, WAIT_D1, WAIT_D2, SYSEX:
  - IDLE: data bytes discarded.
  - WAIT_D1: data byte is latched as d1.
    - C0/D0 status: completes with d2=0; stays WAIT_D1 (running status).
    - Any other status: go to WAIT_D2.
  - WAIT_D2: data byte is latched as d2; message completes; return to WAIT_D1.
  - SYSEX: data bytes discarded until a non-realtime status byte, which is handled as above (F7 goes to IDLE).
- Type mapping:
  - 8n NOTE_OFF; 9n NOTE_ON, but velocity 0 is emitted as NOTE_OFF with d2=0.
  - An POLY_AT; Bn CC; Cn PROG; Dn CHAN_AT; En BEND, with d1=LSB, d2=MSB raw.
- Channel filter: when OMNI=0 and status[3:0]≠CHANNEL, completed messages are dropped; the FSM still advances.
- Latency: byteready_u first sampled high at posedge k completes the message. The event is written at posedge k+2; evt_valid is high from k+2 when the FIFO was empty.
- FIFO:
  - First-word-fall-through with registered outputs.
  - Simultaneous push and pop is allowed at any occupancy, including full; count is then unchanged.
  - Push when full without a pop: the event is dropped, FIFO contents are unchanged, overflow is set.
  - overflow_clr has priority over a same-cycle set.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs hold their value while evt_valid & ~evt_ready.

Optional Feature:
- Macro MIDI_RT_EVT_EN.
- Defined: F8 (clock), FA (start), FB (continue), FC (stop) push events of type RT with evt_d1 = byte[6:0], evt_chan = 0, evt_d2 = 0.
  - No channel filtering.
  - Pushed with the same 2-cycle latency; a data message cannot complete in that same cycle.
- Undefined: all realtime bytes are silently ignored; the RT enum value is unused.

Decomposition:
- Package midi_pkg:
  - evt_type_e enum: NOTE_OFF=0, NOTE_ON=1, POLY_AT=2, CC=3, PROG=4, CHAN_AT=5, BEND=6, RT=7.
  - Status constants: ST_SYSEX=F0, ST_EOX=F7, ST_RT_MIN=F8.
  - midi_evt_t packed struct: type, chan, d1, d2 (21 bits).
- Sub-module midi_evt_fifo: parameterised sync FWFT FIFO of midi_evt_t, with push, pop, full, empty.

Test Plan:
- 90 3C 64, byteready held 200 cycles per byte -> exactly one event NOTE_ON ch0 d1=3C d2=64; evt_valid high 2 clocks after the third byteready edge.
- 93 40 7F 40 00 (running status) -> NOTE_ON ch3 40/7F, then NOTE_OFF ch3 40/00.
- B0 07 F8 65 -> CC d1=07 d2=65. F8 yields an RT event (d1=78) only with MIDI_RT_EVT_EN, emitted before the CC.
- F0 7E 01 F7 then 3C 40 -> no events; run_status=0. Then C5 0A -> PROG ch5 d1=0A d2=0.
- OMNI=0, CHANNEL=2: 91 3C 64 then 92 3C 64 -> only the ch2 event appears.
- evt_ready=0 with 5 complete notes, FIFO_DEPTH=4 -> 4 events held, overflow=1. Pulse overflow_clr -> overflow=0. Drain with evt_ready=1 -> the first 4 events in order.
